// File: rtl/npu_host_seq.sv
// npu_host_seq: host port decode, FC1 weight FIFO and conv->FC inference sequencer
// Ports: clk, rst (async, active-high)
//   host       : ena, wea, addra (sel=[14:12], idx=[11:0]), dina, douta (registered read data)
//   buffers    : wr_en, wr_region, wr_addr, wr_data, wr_be (byte-lane write strobes)
//   engines    : conv_start/conv_done, fc_start/fc_done/fc_logit
//   fc1 stream : fc1_w, fc1_valid, fc1_ready
//   irq        : one-cycle inference-complete pulse
// Option: define NPU_SEQ_TIMEOUT_EN for a TMO_CYC-cycle watchdog in CONV and FC.
module npu_host_seq #(
    parameter int NUM_PE     = 4,
    parameter int IMG_SIZE   = 240,
    parameter int WC_SIZE    = 90,
    parameter int FC2_LEN    = 10,
    parameter int FC1_GROUPS = 33,
    parameter int FIFO_DEPTH = 8,
    parameter int RES_W      = 24,
    parameter int TMO_CYC    = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    wea,
    input  logic [15:0]             addra,
    input  logic [31:0]             dina,
    output logic [31:0]             douta,
    output logic                    wr_en,
    output logic [2:0]              wr_region,
    output logic [13:0]             wr_addr,
    output logic [31:0]             wr_data,
    output logic [3:0]              wr_be,
    output logic                    conv_start,
    input  logic                    conv_done,
    output logic                    fc_start,
    input  logic                    fc_done,
    input  logic signed [RES_W-1:0] fc_logit,
    output logic [8*NUM_PE-1:0]     fc1_w,
    output logic                    fc1_valid,
    input  logic                    fc1_ready,
    output logic                    irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(FC1_GROUPS + 1);
    typedef enum logic [1:0] {IDLE, CONV, FC, DONE} state_t;
    state_t                  state;
    logic                    h_wr, h_rd;
    logic [2:0]              h_sel;
    logic [11:0]             h_idx;
    logic [31:0]             h_data;
    logic [8*NUM_PE-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]             wp, rp, count;
    logic [GW-1:0]           grp_cnt;
    logic                    done, err, ovf, tmo, busy, full, push, pop, start, clear, tmo_hit;
    logic signed [RES_W-1:0] result;
    logic [2:0]              sel;
    logic [13:0]             base;
    logic [3:0]              be;
    logic [31:0]             status;
    int                      lim;
    logic                    unused_bits;

    assign unused_bits = ^{addra[15], TMO_CYC[0]};

    // Byte-lane enables come straight from the incoming address so the strobe
    // lands one cycle after the host edge.
    always_comb begin
        sel  = addra[14:12];
        base = {addra[11:0], 2'b00};
        lim  = (sel == 3'b001 || sel == 3'b010) ? WC_SIZE :
               sel == 3'b100 ? FC2_LEN : sel == 3'b110 ? IMG_SIZE : 0;
        be   = '0;
        for (int k = 0; k < 4; k++) be[k] = int'(base) + k < lim;
    end

    assign push      = h_wr && h_sel == 3'b011;
    assign start     = h_wr && h_sel == 3'b101 && h_idx == 12'd0;
    assign clear     = h_wr && h_sel == 3'b101 && h_idx == 12'd1;
    assign count     = wp - rp;
    assign full      = count == FIFO_DEPTH[AW:0];
    assign busy      = state == CONV || state == FC;
    assign fc1_valid = state == FC && count != '0 && grp_cnt < FC1_GROUPS[GW-1:0];
    assign pop       = fc1_valid && fc1_ready;
    assign fc1_w     = mem[rp[AW-1:0]];
    assign status    = {16'b0, 8'(count), 3'b0, tmo, ovf, err, busy, done};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            h_wr      <= 1'b0;
            h_rd      <= 1'b0;
            h_sel     <= '0;
            h_idx     <= '0;
            h_data    <= '0;
            wr_en     <= 1'b0;
            wr_region <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_be     <= '0;
            douta     <= '0;
        end else begin
            h_wr      <= ena && wea;
            h_rd      <= ena && !wea;
            h_sel     <= sel;
            h_idx     <= addra[11:0];
            h_data    <= dina;
            wr_en     <= ena && wea && |be;
            wr_region <= sel;
            wr_addr   <= base;
            wr_data   <= dina;
            wr_be     <= (ena && wea) ? be : 4'b0;
            if (h_rd)
                douta <= h_sel != 3'b111 ? '0 : h_idx == 12'd0 ? status :
                         h_idx == 12'd1 ? 32'(result) : '0;
        end

    // A push into a full FIFO still lands when the head pops in the same cycle.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && (!full || pop)) begin
                mem[wp[AW-1:0]] <= h_data[8*NUM_PE-1:0];
                wp              <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end

`ifdef NPU_SEQ_TIMEOUT_EN
    logic [31:0] wdog;
    always_ff @(posedge clk or posedge rst)
        if (rst) wdog <= '0;
        else wdog <= (!busy || (state == CONV && conv_done) || pop) ? '0 : wdog + 1'b1;
    assign tmo_hit = busy && wdog == 32'(TMO_CYC - 1);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            conv_start <= 1'b0;
            fc_start   <= 1'b0;
            irq        <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            tmo        <= 1'b0;
            result     <= '0;
            grp_cnt    <= '0;
        end else begin
            conv_start <= 1'b0;
            fc_start   <= 1'b0;
            irq        <= 1'b0;
            if (push && full && !pop) ovf <= 1'b1;
            if (clear) begin
                state <= IDLE;
                done  <= 1'b0;
                err   <= 1'b0;
                ovf   <= 1'b0;
                tmo   <= 1'b0;
            end else if (start && !busy) begin
                state      <= CONV;
                conv_start <= 1'b1;
                done       <= 1'b0;
                grp_cnt    <= '0;
            end else if (tmo_hit) begin
                state <= IDLE;
                tmo   <= 1'b1;
                err   <= 1'b1;
            end else begin
                if (start) err <= 1'b1;
                if (state == CONV && conv_done) begin
                    state    <= FC;
                    fc_start <= 1'b1;
                end
                if (state == FC) begin
                    if (pop) grp_cnt <= grp_cnt + 1'b1;
                    if (fc_done) begin
                        state  <= DONE;
                        result <= fc_logit;
                        done   <= 1'b1;
                        irq    <= 1'b1;
                        if (grp_cnt != FC1_GROUPS[GW-1:0]) err <= 1'b1;
                    end
                end
            end
        end
endmodule

// File: tb/tb_npu_host_seq.sv
// tb_npu_host_seq: directed self-checking bench for npu_host_seq
module tb_npu_host_seq;
    logic              clk = 1'b0, rst = 1'b1, ena = 1'b0, wea = 1'b0;
    logic              conv_done = 1'b0, fc_done = 1'b0, fc1_ready = 1'b0;
    logic [15:0]       addra = '0;
    logic [31:0]       dina = '0;
    logic signed [23:0] fc_logit = '0;
    logic [31:0]       douta, wr_data, fc1_w, rd;
    logic [2:0]        wr_region;
    logic [13:0]       wr_addr;
    logic [3:0]        wr_be;
    logic              wr_en, conv_start, fc_start, fc1_valid, irq;
    int                n_chk = 0, n_fail = 0, n_xfer = 0;
    logic [31:0]       got [64];

    npu_host_seq #(.TMO_CYC(100)) dut (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta), .wr_en(wr_en), .wr_region(wr_region), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .conv_start(conv_start), .conv_done(conv_done),
        .fc_start(fc_start), .fc_done(fc_done), .fc_logit(fc_logit), .fc1_w(fc1_w),
        .fc1_valid(fc1_valid), .fc1_ready(fc1_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (fc1_valid && fc1_ready) begin
            if (n_xfer < 64) got[n_xfer] = fc1_w;
            n_xfer++;
        end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
        ena = 1'b1; wea = 1'b1; addra = a; dina = d;
        tick(1);
        ena = 1'b0; wea = 1'b0;
    endtask

    task automatic host_rd(input logic [15:0] a, output logic [31:0] d);
        ena = 1'b1; wea = 1'b0; addra = a;
        tick(1);
        ena = 1'b0;
        tick(1);
        d = douta;
    endtask

    task automatic test_reset;
        tick(3);
        n_chk++;
        if ({wr_en, wr_be, conv_start, fc_start, irq, fc1_valid} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_pulses got %b exp 0", {wr_en, wr_be, conv_start, fc_start, irq, fc1_valid});
        end
        n_chk++;
        if ({douta, fc1_w} !== 64'b0) begin
            n_fail++;
            $display("FAIL reset_data got douta=%h fc1_w=%h exp 0", douta, fc1_w);
        end
        rst = 1'b0;
        tick(1);
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status got %h exp 00000000", rd);
        end
    endtask

    task automatic test_decode;
        host_wr(16'h603B, 32'hAABBCCDD);
        n_chk++;
        if ({wr_en, wr_region, wr_addr, wr_be, wr_data} !== {1'b1, 3'd6, 14'd236, 4'hF, 32'hAABBCCDD}) begin
            n_fail++;
            $display("FAIL img_59 got en=%b reg=%0d addr=%0d be=%h data=%h exp 1 6 236 f aabbccdd",
                     wr_en, wr_region, wr_addr, wr_be, wr_data);
        end
        tick(1);
        n_chk++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_en_pulse got %b exp 0", wr_en);
        end
        host_wr(16'h603C, 32'h12345678);
        n_chk++;
        if ({wr_en, wr_be} !== 5'b0) begin
            n_fail++;
            $display("FAIL img_60 got en=%b be=%h exp 0 0", wr_en, wr_be);
        end
        host_wr(16'h4002, 32'h11223344);
        n_chk++;
        if ({wr_en, wr_region, wr_addr, wr_be} !== {1'b1, 3'd4, 14'd8, 4'h3}) begin
            n_fail++;
            $display("FAIL fc2_2 got en=%b reg=%0d addr=%0d be=%h exp 1 4 8 3", wr_en, wr_region, wr_addr, wr_be);
        end
        host_wr(16'h1016, 32'h55667788);
        n_chk++;
        if ({wr_en, wr_region, wr_addr, wr_be} !== {1'b1, 3'd1, 14'd88, 4'h3}) begin
            n_fail++;
            $display("FAIL conv1_22 got en=%b reg=%0d addr=%0d be=%h exp 1 1 88 3", wr_en, wr_region, wr_addr, wr_be);
        end
        host_wr(16'h2017, 32'h55667788);
        n_chk++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL conv2_23 got en=%b exp 0", wr_en);
        end
        host_wr(16'h7000, 32'hFFFFFFFF);
        n_chk++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ro_write got en=%b exp 0", wr_en);
        end
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL ro_status got %h exp 00000000", rd);
        end
    endtask

    task automatic test_full_inference;
        int k = 0;
        n_xfer = 0;
        host_wr(16'h5000, 32'h0);
        tick(1);
        n_chk++;
        if (conv_start !== 1'b1) begin
            n_fail++;
            $display("FAIL conv_start got %b exp 1", conv_start);
        end
        tick(1);
        n_chk++;
        if (conv_start !== 1'b0) begin
            n_fail++;
            $display("FAIL conv_start_pulse got %b exp 0", conv_start);
        end
        tick(8);
        conv_done = 1'b1;
        tick(1);
        conv_done = 1'b0;
        n_chk++;
        if (fc_start !== 1'b1) begin
            n_fail++;
            $display("FAIL fc_start got %b exp 1", fc_start);
        end
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h2) begin
            n_fail++;
            $display("FAIL fc_busy got %h exp 00000002", rd);
        end
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < (s == 4 ? 1 : 8); i++) begin
                ena = 1'b1; wea = 1'b1; addra = 16'h3000; dina = 32'hC0DE0000 + k;
                k++;
                fc1_ready = ~fc1_ready;
                tick(1);
            end
            ena = 1'b0; wea = 1'b0;
            repeat (16) begin
                fc1_ready = ~fc1_ready;
                tick(1);
            end
        end
        for (int c = 0; c < 100 && n_xfer < 33; c++) begin
            fc1_ready = ~fc1_ready;
            tick(1);
        end
        n_chk++;
        if (n_xfer !== 33) begin
            n_fail++;
            $display("FAIL xfer_count got %0d exp 33", n_xfer);
        end
        for (int i = 0; i < 33; i++) begin
            n_chk++;
            if (got[i] !== 32'hC0DE0000 + i) begin
                n_fail++;
                $display("FAIL xfer_order[%0d] got %h exp %h", i, got[i], 32'hC0DE0000 + i);
            end
        end
        fc1_ready = 1'b1;
        host_wr(16'h3000, 32'hDEAD0001);
        tick(3);
        n_chk++;
        if ({fc1_valid, 32'(n_xfer)} !== {1'b0, 32'd33}) begin
            n_fail++;
            $display("FAIL grp_cap got valid=%b xfers=%0d exp 0 33", fc1_valid, n_xfer);
        end
        fc_logit = -24'sd5;
        fc_done = 1'b1;
        tick(1);
        fc_done = 1'b0;
        n_chk++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq got %b exp 1", irq);
        end
        tick(1);
        n_chk++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_pulse got %b exp 0", irq);
        end
        host_rd(16'h7001, rd);
        n_chk++;
        if (rd !== 32'hFFFFFFFB) begin
            n_fail++;
            $display("FAIL result got %h exp fffffffb", rd);
        end
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h00000101) begin
            n_fail++;
            $display("FAIL done_status got %h exp 00000101", rd);
        end
    endtask

    task automatic test_overflow;
        host_wr(16'h5001, 32'h0);
        fc1_ready = 1'b0;
        for (int i = 1; i <= 9; i++) host_wr(16'h3000, 32'(i));
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h00000808) begin
            n_fail++;
            $display("FAIL ovf_status got %h exp 00000808", rd);
        end
        n_xfer = 0;
        fc1_ready = 1'b1;
        host_wr(16'h5000, 32'h0);
        tick(1);
        conv_done = 1'b1;
        tick(1);
        conv_done = 1'b0;
        tick(20);
        n_chk++;
        if (n_xfer !== 8) begin
            n_fail++;
            $display("FAIL ovf_xfers got %0d exp 8", n_xfer);
        end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (got[i] !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL ovf_order[%0d] got %h exp %h", i, got[i], 32'(i + 1));
            end
        end
        fc_logit = 24'sh012345;
        fc_done = 1'b1;
        tick(1);
        fc_done = 1'b0;
        n_chk++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL early_irq got %b exp 1", irq);
        end
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h0000000D) begin
            n_fail++;
            $display("FAIL early_status got %h exp 0000000d", rd);
        end
        host_rd(16'h7001, rd);
        n_chk++;
        if (rd !== 32'h00012345) begin
            n_fail++;
            $display("FAIL early_result got %h exp 00012345", rd);
        end
        host_wr(16'h5001, 32'h0);
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_status got %h exp 00000000", rd);
        end
    endtask

    task automatic test_start_during_conv;
        int pulses;
        host_wr(16'h5000, 32'h0);
        tick(1);
        n_chk++;
        if (conv_start !== 1'b1) begin
            n_fail++;
            $display("FAIL conv_start2 got %b exp 1", conv_start);
        end
        host_wr(16'h5000, 32'h0);
        pulses = int'(conv_start);
        repeat (4) begin
            tick(1);
            pulses += int'(conv_start);
        end
        n_chk++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL restart_pulses got %0d exp 0", pulses);
        end
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h00000006) begin
            n_fail++;
            $display("FAIL restart_status got %h exp 00000006", rd);
        end
        host_wr(16'h5001, 32'h0);
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL clear2_status got %h exp 00000000", rd);
        end
        conv_done = 1'b1;
        tick(1);
        conv_done = 1'b0;
        n_chk++;
        if (fc_start !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_conv_done got %b exp 0", fc_start);
        end
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_status got %h exp 00000000", rd);
        end
    endtask

    task automatic test_timeout;
        host_wr(16'h5000, 32'h0);
        tick(1);
`ifdef NPU_SEQ_TIMEOUT_EN
        tick(50);
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h00000002) begin
            n_fail++;
            $display("FAIL tmo_early got %h exp 00000002", rd);
        end
        tick(60);
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h00000014) begin
            n_fail++;
            $display("FAIL tmo_status got %h exp 00000014", rd);
        end
`else
        tick(1000);
        host_rd(16'h7000, rd);
        n_chk++;
        if (rd !== 32'h00000002) begin
            n_fail++;
            $display("FAIL no_tmo_status got %h exp 00000002", rd);
        end
`endif
        host_wr(16'h5001, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decode();
        test_full_inference();
        test_overflow();
        test_start_during_conv();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
